// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: controller FSM plus A/Q/Q_-1/M datapath.
// Operands come in over a valid/ready handshake. The signed 2*WIDTH-bit product
// goes out over a second valid/ready handshake.
// Optional macro BOOTH_SKIP_EN: for a 00/11 Booth pair the ADD state also does
// the shift and count update, so the SHIFT state is skipped for that step.
module booth_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           booth_sel,
  output logic                 busy
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [AW-1:0]   a;
  logic [AW-1:0]   m;
  logic [WIDTH-1:0] q;
  logic            q_m1;
  logic [CW-1:0]   count;

  logic [1:0]      sel;
  logic [AW-1:0]   a_add;
  logic [AW-1:0]   sh_a;
  logic [WIDTH-1:0] sh_q;
  logic [PW-1:0]   sh_prod;
  logic [CW-1:0]   count_inc;
  logic            last_step;
  logic            load;
  logic            do_shift;

  // Booth step arithmetic and the one-bit arithmetic right shift of {A,Q,Q_-1}
  always_comb begin
    sel       = {q[0], q_m1};
    unique case (sel)
      2'b01:   a_add = a + m;
      2'b10:   a_add = a - m;
      default: a_add = a;
    endcase
    sh_a      = {a[AW-1], a[AW-1:1]};
    sh_q      = {a[0], q[WIDTH-1:1]};
    sh_prod   = {sh_a[WIDTH-1:0], sh_q};
    count_inc = count + CW'(1);
    last_step = (count_inc == CW'(WIDTH));
    load      = (state == S_IDLE) && in_valid;
  end

`ifdef BOOTH_SKIP_EN
  logic sel_nop;

  // A 00/11 pair leaves A unchanged, so the shift can happen in the ADD cycle
  always_comb begin
    sel_nop  = (sel == 2'b00) || (sel == 2'b11);
    do_shift = (state == S_SHIFT) || ((state == S_ADD) && sel_nop);
  end
`else
  // Shift only in the dedicated SHIFT state
  always_comb begin
    do_shift = (state == S_SHIFT);
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (in_valid) state_nxt = S_ADD;
        S_ADD: begin
          if (do_shift) state_nxt = last_step ? S_DONE : S_ADD;
          else          state_nxt = S_SHIFT;
        end
        S_SHIFT: state_nxt = last_step ? S_DONE : S_ADD;
        S_DONE:  if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register; booth_sel forced to 00 in IDLE
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    booth_sel = 2'b00;
    unique case (state)
      S_IDLE:  in_ready = 1'b1;
      S_ADD,
      S_SHIFT: begin
        busy      = 1'b1;
        booth_sel = sel;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        booth_sel = sel;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath registers; product is captured from the final shifted value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      product <= '0;
    end else if (flush) begin
      count   <= '0;
    end else if (load) begin
      a       <= '0;
      m       <= {multiplicand[WIDTH-1], multiplicand};
      q       <= multiplier;
      q_m1    <= 1'b0;
      count   <= '0;
    end else if (do_shift) begin
      a       <= sh_a;
      q       <= sh_q;
      q_m1    <= q[0];
      count   <= count_inc;
      if (last_step) product <= sh_prod;
    end else if (state == S_ADD) begin
      a       <= a_add;
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl (WIDTH=16). Expected products are hand-computed.
// Latency expectations follow the build: BOOTH_SKIP_EN changes the cycle counts.
module tb_booth_seq_ctrl;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           flush = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] product;
  logic [1:0]     booth_sel;
  logic           busy;

  int total = 0;
  int bad = 0;
  int lat;
  logic [1:0] trace [0:127];

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .booth_sel(booth_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles from accept edge to first out_valid, derived from the multiplier bits
  function automatic int exp_lat(input logic [W-1:0] mp);
    int n;
    logic prev;
`ifdef BOOTH_SKIP_EN
    n = W;
    prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (mp[i] != prev) n++;
      prev = mp[i];
    end
`else
    n = 2 * W;
    prev = 1'b0;
`endif
    return n;
  endfunction

  task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mp,
                        input logic [2*W-1:0] exp, input string tag);
    int hi;
    in_valid = 1'b1;
    multiplicand = mc;
    multiplier = mp;
    step();
    in_valid = 1'b0;
    hi = 0;
    lat = 0;
    trace[0] = booth_sel;
    while (!out_valid && lat < 100) begin
      if (in_ready) hi++;
      step();
      lat++;
      trace[lat] = booth_sel;
    end
    check({tag, "_ovalid"}, 64'(out_valid), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(mp)));
    check({tag, "_inrdy_low"}, 64'(hi), 64'd0);
    check({tag, "_prod"}, 64'(product), 64'(exp));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_hs_ovalid"}, 64'(out_valid), 64'd0);
    check({tag, "_hs_inrdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [1:0] exps [0:4];
    logic [2*W-1:0] held;
    int idx;
    int seen;

    exps[0] = 2'b00; exps[1] = 2'b10; exps[2] = 2'b11; exps[3] = 2'b01; exps[4] = 2'b00;

    // Reset values
    step();
    step();
    check("rst_inrdy", 64'(in_ready), 64'd1);
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sel", 64'(booth_sel), 64'd0);
    check("rst_prod", 64'(product), 64'd0);
    rst_n = 1'b1;
    step();

    // 3 * 5
    run_op(16'd3, 16'd5, 32'h0000_000F, "m3x5");
    handshake("m3x5");

    // -7 * 6 with the Booth select seen in each ADD step
    run_op(16'hFFF9, 16'h0006, 32'hFFFF_FFD6, "mn7x6");
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("sel_step%0d", k), 64'(trace[idx]), 64'(exps[k]));
`ifdef BOOTH_SKIP_EN
      idx += (exps[k] == 2'b00 || exps[k] == 2'b11) ? 1 : 2;
`else
      idx += 2;
`endif
    end
    handshake("mn7x6");

    // Signed corner cases
    run_op(16'h8000, 16'h8000, 32'h4000_0000, "min_min");
    handshake("min_min");
    run_op(16'h7FFF, 16'h8000, 32'hC000_8000, "max_min");
    handshake("max_min");
    run_op(16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "max_max");
    handshake("max_max");
    run_op(16'hFFFF, 16'hFFFF, 32'h0000_0001, "m1xm1");
    handshake("m1xm1");

    // Backpressure: product held; in_valid in DONE is not accepted
    run_op(16'd100, 16'hFFFD, 32'hFFFF_FED4, "bp");
    held = product;
    in_valid = 1'b1;
    multiplicand = 16'd1;
    multiplier = 16'd1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp_ovalid%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("bp_prod%0d", c), 64'(product), 64'(held));
      check($sformatf("bp_inrdy%0d", c), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    check("bp_idle_busy", 64'(busy), 64'd0);

    // Flush at cycle 10 of an operation, in_valid ignored in the flush cycle
    held = product;
    in_valid = 1'b1;
    multiplicand = 16'd9;
    multiplier = 16'd9;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    in_valid = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_inrdy", 64'(in_ready), 64'd1);
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_ovalid", 64'(out_valid), 64'd0);
    check("fl_sel", 64'(booth_sel), 64'd0);
    check("fl_prod", 64'(product), 64'(held));
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid || busy) seen++;
    end
    check("fl_quiet", 64'(seen), 64'd0);

    // Asynchronous reset mid-operation
    in_valid = 1'b1;
    multiplicand = 16'h1234;
    multiplier = 16'h0F0F;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1;
    check("ar_inrdy", 64'(in_ready), 64'd1);
    check("ar_ovalid", 64'(out_valid), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_sel", 64'(booth_sel), 64'd0);
    check("ar_prod", 64'(product), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Zero multiplier after reset recovery
    run_op(16'd123, 16'd0, 32'h0000_0000, "m123x0");
    handshake("m123x0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
